// File: rtl/clk_switch_ctrl.sv
// Clock-source switch controller: drives a 2:1 glitch-free clock mux and waits for it to settle.
// Define CLK_SW_ACK_TIMEOUT_EN to abort and revert when the acknowledge takes too long.
module clk_switch_ctrl #(
  parameter int unsigned DWELL_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT  = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic io_req_valid,
  input  logic io_req_sel,
  output logic io_req_ready,
  output logic io_clksel,
  input  logic io_clkact,
  output logic io_cur_sel,
  output logic io_busy,
  output logic io_done,
  output logic io_err
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_ACK = 2'd1;
  localparam logic [1:0] ST_DWELL    = 2'd2;

  localparam logic [15:0] DWELL_LOAD = 16'(DWELL_CYCLES - 1);

  if (DWELL_CYCLES < 1 || DWELL_CYCLES > 65535 || ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535)
  begin : g_bad_param
    $error("clk_switch_ctrl: DWELL_CYCLES and ACK_TIMEOUT must be in 1..65535");
  end

  logic       act_meta;
  logic       act_sync;
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       clksel_q;
  logic       clksel_d;
  logic       cur_sel_q;
  logic       cur_sel_d;
  logic [15:0] dwell_q;
  logic [15:0] dwell_d;
  logic       done_q;
  logic       done_d;

  // io_clkact comes from the switched clock domain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      act_meta <= 1'b0;
      act_sync <= 1'b0;
    end else begin
      act_meta <= io_clkact;
      act_sync <= act_meta;
    end
  end

`ifdef CLK_SW_ACK_TIMEOUT_EN
  localparam logic [15:0] ACK_LIMIT = 16'(ACK_TIMEOUT);

  logic        prev_sel_q;
  logic        prev_sel_d;
  logic [15:0] to_cnt_q;
  logic [15:0] to_cnt_d;
  logic        err_q;
  logic        err_d;
  logic        abort_q;
  logic        abort_d;
`endif

  always_comb begin
    state_d   = state_q;
    clksel_d  = clksel_q;
    cur_sel_d = cur_sel_q;
    dwell_d   = dwell_q;
    done_d    = 1'b0;
`ifdef CLK_SW_ACK_TIMEOUT_EN
    prev_sel_d = prev_sel_q;
    to_cnt_d   = to_cnt_q;
    err_d      = 1'b0;
    abort_d    = abort_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (io_req_valid) begin
          if (io_req_sel == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            clksel_d = io_req_sel;
            state_d  = ST_WAIT_ACK;
`ifdef CLK_SW_ACK_TIMEOUT_EN
            prev_sel_d = clksel_q;
            to_cnt_d   = 16'd0;
            abort_d    = 1'b0;
`endif
          end
        end
      end

      ST_WAIT_ACK: begin
`ifdef CLK_SW_ACK_TIMEOUT_EN
        if (to_cnt_q != 16'hffff) begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
        // An acknowledge wins over a timeout that expires on the same cycle.
        if (act_sync == clksel_q) begin
          cur_sel_d = clksel_q;
          dwell_d   = DWELL_LOAD;
          state_d   = ST_DWELL;
        end
`ifdef CLK_SW_ACK_TIMEOUT_EN
        else if (to_cnt_q >= ACK_LIMIT) begin
          clksel_d = prev_sel_q;
          err_d    = 1'b1;
          abort_d  = 1'b1;
          dwell_d  = DWELL_LOAD;
          state_d  = ST_DWELL;
        end
`endif
      end

      ST_DWELL: begin
        if (dwell_q == 16'd0) begin
          state_d = ST_IDLE;
`ifdef CLK_SW_ACK_TIMEOUT_EN
          done_d = ~abort_q;
`else
          done_d = 1'b1;
`endif
        end else begin
          dwell_d = dwell_q - 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      clksel_q  <= 1'b0;
      cur_sel_q <= 1'b0;
      dwell_q   <= 16'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clksel_q  <= clksel_d;
      cur_sel_q <= cur_sel_d;
      dwell_q   <= dwell_d;
      done_q    <= done_d;
    end
  end

`ifdef CLK_SW_ACK_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_sel_q <= 1'b0;
      to_cnt_q   <= 16'd0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      prev_sel_q <= prev_sel_d;
      to_cnt_q   <= to_cnt_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
    end
  end

  assign io_err = err_q;
`else
  assign io_err = 1'b0;
`endif

  assign io_req_ready = (state_q == ST_IDLE);
  assign io_busy      = (state_q == ST_WAIT_ACK) || (state_q == ST_DWELL);
  assign io_clksel    = clksel_q;
  assign io_cur_sel   = cur_sel_q;
  assign io_done      = done_q;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl: directed vector table, hand-written corner sequences and
// randomized traffic checked against a timestamp-based reference model.
module tb_clk_switch_ctrl;

  localparam int DWELL = 4;
  localparam int ACKTO = 8;
`ifdef CLK_SW_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0;
  logic req_sel = 1'b0;
  logic clkact = 1'b0;
  logic req_ready, clksel, cur_sel, busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  clk_switch_ctrl #(
    .DWELL_CYCLES(DWELL),
    .ACK_TIMEOUT (ACKTO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .io_req_valid(req_valid),
    .io_req_sel  (req_sel),
    .io_req_ready(req_ready),
    .io_clksel   (clksel),
    .io_clkact   (clkact),
    .io_cur_sel  (cur_sel),
    .io_busy     (busy),
    .io_done     (done),
    .io_err      (err)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // Output vector layout: {ready, clksel, cur_sel, busy, done, err}
  function automatic logic [5:0] outs();
    return {req_ready, clksel, cur_sel, busy, done, err};
  endfunction

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: absolute edge numbers and deadlines rather than an FSM.
  int m_now, m_accept_at, m_settle_end, m_done_at, m_err_at;
  bit m_waiting, m_clksel, m_cur, m_prev;
  bit m_hist[$];

  function automatic void model_reset();
    m_now = 0; m_accept_at = 0; m_settle_end = 0; m_done_at = -1; m_err_at = -1;
    m_waiting = 0; m_clksel = 0; m_cur = 0; m_prev = 0;
    m_hist = {1'b0, 1'b0};
  endfunction

  function automatic void model_edge(input bit v, input bit s, input bit a);
    bit seen;
    seen = m_hist[0];  // act as seen through two sync flops
    m_now++;
    if (!m_waiting && (m_now - 1) >= m_settle_end) begin
      if (v) begin
        if (s == m_cur) m_done_at = m_now;
        else begin
          m_prev = m_clksel; m_clksel = s; m_waiting = 1; m_accept_at = m_now;
        end
      end
    end else if (m_waiting) begin
      if (seen == m_clksel) begin
        m_waiting = 0; m_cur = m_clksel;
        m_settle_end = m_now + DWELL; m_done_at = m_settle_end;
      end else if (TO_EN && m_now == m_accept_at + ACKTO + 1) begin
        m_waiting = 0; m_clksel = m_prev; m_err_at = m_now;
        m_settle_end = m_now + DWELL;
      end
    end
    m_hist.push_back(a);
    void'(m_hist.pop_front());
  endfunction

  function automatic logic [5:0] model_outs();
    bit b;
    b = m_waiting || (m_now < m_settle_end);
    return {!b, m_clksel, m_cur, b, m_now == m_done_at, m_now == m_err_at};
  endfunction

  task automatic cycle(input bit v, input bit s, input bit a);
    req_valid = v; req_sel = s; clkact = a;
    model_edge(v, s, a);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = 1'b0; req_sel = 1'b0; clkact = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    model_reset();
    check("reset_state", int'(outs()), int'(6'b100000));
    reset = 1'b1;
  endtask

  typedef struct {
    bit         v;
    bit         s;
    bit         a;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[19];
  int   err_at, done_at, idle_at;
  bit   saw_done, saw_err;
  bit   rv, rs, ra;

  initial begin
    // Basic switch 0->1, request ignored while busy, switch back, same-source request.
    tbl[0]  = '{1, 1, 0, 6'b010100};
    tbl[1]  = '{0, 0, 1, 6'b010100};
    tbl[2]  = '{0, 0, 1, 6'b010100};
    tbl[3]  = '{0, 0, 1, 6'b011100};
    tbl[4]  = '{1, 0, 1, 6'b011100};
    tbl[5]  = '{1, 0, 1, 6'b011100};
    tbl[6]  = '{1, 0, 1, 6'b011100};
    tbl[7]  = '{1, 0, 1, 6'b111010};
    tbl[8]  = '{1, 0, 1, 6'b001100};
    tbl[9]  = '{0, 0, 0, 6'b001100};
    tbl[10] = '{0, 0, 0, 6'b001100};
    tbl[11] = '{0, 0, 0, 6'b000100};
    tbl[12] = '{0, 0, 0, 6'b000100};
    tbl[13] = '{0, 0, 0, 6'b000100};
    tbl[14] = '{0, 0, 0, 6'b000100};
    tbl[15] = '{0, 0, 0, 6'b100010};
    tbl[16] = '{0, 0, 0, 6'b100000};
    tbl[17] = '{1, 0, 0, 6'b100010};
    tbl[18] = '{0, 0, 0, 6'b100000};

    #1;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].a);
      check($sformatf("table_row%0d", i), int'(outs()), int'(tbl[i].exp));
    end

    // Acknowledge never arrives.
    cycle(1, 1, 0);
    err_at = -1; idle_at = -1; saw_done = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle(0, 0, 0);
      if (err && err_at < 0) err_at = k;
      if (done) saw_done = 1;
      if (!busy) begin
        idle_at = k;
        break;
      end
    end
`ifdef CLK_SW_ACK_TIMEOUT_EN
    check("timeout_err_cycle", err_at, ACKTO + 1);
    check("timeout_idle_cycle", idle_at, ACKTO + 1 + DWELL);
    check("timeout_no_done", int'(saw_done), 0);
    check("timeout_revert_clksel_cursel", int'({clksel, cur_sel}), 0);
`else
    check("stuck_ack_still_busy", idle_at, -1);
    check("stuck_ack_no_err", err_at, -1);
    check("stuck_ack_clksel", int'(clksel), 1);
    saw_done = 0;
    for (int k = 1; k <= 12 && !saw_done; k++) begin
      cycle(0, 0, 1);
      if (done) saw_done = 1;
    end
    check("late_ack_completes", int'({saw_done, cur_sel, busy}), int'(3'b110));
`endif

    // Acknowledge lands exactly on the timeout cycle.
    do_reset();
    cycle(1, 1, 0);
    done_at = -1; saw_err = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle(0, 0, k >= 7);
      if (err) saw_err = 1;
      if (done && done_at < 0) done_at = k;
    end
    check("ack_at_timeout_no_err", int'(saw_err), 0);
    check("ack_at_timeout_done_cycle", done_at, ACKTO + 1 + DWELL);
    check("ack_at_timeout_cur_sel", int'(cur_sel), 1);

    // Same-source request while on source 1.
    cycle(1, 1, 1);
    check("same_sel_done", int'(outs()), int'(6'b111010));
    cycle(0, 0, 1);
    check("same_sel_after", int'(outs()), int'(6'b111000));

    // Reset in the middle of WAIT_ACK.
    do_reset();
    cycle(1, 1, 0);
    cycle(0, 0, 0);
    check("pre_reset_wait", int'(outs()), int'(6'b010100));
    #3 reset = 1'b0;
    #1;
    check("async_reset_outputs", int'(outs()), int'(6'b100000));
    saw_done = 0; saw_err = 0;
    repeat (2) begin
      @(posedge clock); #1;
      if (done) saw_done = 1;
      if (err) saw_err = 1;
    end
    check("reset_no_pulse", int'({saw_done, saw_err}), 0);
    reset = 1'b1;
    model_reset();

    // Randomized traffic against the model.
    ra = 0;
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 2) == 0);
      rs = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ra = m_clksel;
      cycle(rv, rs, ra);
      check("random_outputs", int'(outs()), int'(model_outs()));
      check("done_err_exclusive", int'(done & err), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_switch_ctrl.md
CLK_SWITCH_CTRL -- requirements
Module: clk_switch_ctrl

Interface
REQ-001 Parameter DWELL_CYCLES, default 16: post-switch settle time in clock cycles, legal range 1..65535.
REQ-002 Parameter ACK_TIMEOUT, default 256: maximum cycles to wait for the switch acknowledge, legal range 1..65535.
REQ-003 clock  input  1  free-running reference clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 io_req_valid  input  1  switch request valid.
REQ-006 io_req_sel  input  1  requested clock source: 0 = clkin_0, 1 = clkin_1.
REQ-007 io_req_ready  output  1  controller can accept a request.
REQ-008 io_clksel  output  1  select line to the 2:1 glitch-free clock switch.
REQ-009 io_clkact  input  1  switch status: currently active source, asynchronous to clock.
REQ-010 io_cur_sel  output  1  last source confirmed active.
REQ-011 io_busy  output  1  switch sequence in progress.
REQ-012 io_done  output  1  one-cycle pulse when a request completes.
REQ-013 io_err  output  1  one-cycle pulse when a request aborts on timeout.

Function
REQ-014 io_clkact shall pass through a 2-flop synchronizer; "act" below means the synchronizer output.
REQ-015 The FSM shall have three states: IDLE, WAIT_ACK and DWELL.
REQ-016 io_req_ready shall be 1 only in IDLE; a request is accepted on a cycle with io_req_valid=1 and io_req_ready=1.
REQ-017 Accepted request with io_req_sel==io_cur_sel: no state change, no io_clksel change, io_done pulses the next cycle.
REQ-018 Accepted request with io_req_sel!=io_cur_sel: next cycle io_clksel=io_req_sel, the state is WAIT_ACK, the timeout counter is 0 and the previous source is saved.
REQ-019 WAIT_ACK: the timeout counter increments each cycle; when act==io_clksel, io_cur_sel<=io_clksel, the dwell counter loads DWELL_CYCLES-1 and the state becomes DWELL.
REQ-020 DWELL: the dwell counter decrements each cycle; at 0 the state becomes IDLE and io_done pulses on the same transition edge.
REQ-021 io_busy shall be 1 exactly while the state is WAIT_ACK or DWELL.
REQ-022 io_req_sel shall be sampled only on acceptance; io_req_valid/io_req_sel changes while busy shall be ignored, with no queuing.
REQ-023 Counters shall be 16 bits and saturate rather than wrap.
REQ-024 If act matches in the same cycle the timeout expires, the acknowledge shall take priority: no error, and the flow continues to DWELL.
REQ-025 io_done and io_err shall never be asserted in the same cycle.

Reset
REQ-026 Asserting reset shall immediately force state IDLE, io_clksel=0, io_cur_sel=0, io_busy=0, io_done=0, io_err=0, all counters 0 and synchronizer flops 0.
REQ-027 After reset deassertion, io_req_ready shall be 1 from the first clock edge.
REQ-028 Reset asserted mid-sequence shall abort the sequence with no io_done or io_err pulse, and io_clksel shall return to 0 asynchronously.

Configuration
REQ-029 Macro CLK_SW_ACK_TIMEOUT_EN, defined: when the timeout counter reaches ACK_TIMEOUT in WAIT_ACK, io_clksel shall revert to the saved previous source, io_err shall pulse, io_cur_sel shall be unchanged, and the state shall become DWELL (full DWELL_CYCLES) before IDLE, with no io_done.
REQ-030 Macro undefined: the timeout counter and io_err logic shall be absent, io_err shall be tied to 0, and WAIT_ACK shall wait indefinitely.

Verification
REQ-031 Reset release, then req_valid=1 with req_sel=1 and act following clksel after 5 cycles -> clksel=1 one cycle after acceptance; busy for about 2+5+16 cycles; cur_sel=1; one done pulse; ready returns to 1.
REQ-032 cur_sel=1, request req_sel=1 -> done pulses the next cycle; busy stays 0; clksel stays 1.
REQ-033 A second request (req_sel=0) held valid during DWELL -> ignored while busy; accepted on the first IDLE cycle; second switch completes with cur_sel=0.
REQ-034 CLK_SW_ACK_TIMEOUT_EN defined, ACK_TIMEOUT=8, act stuck at 0, request req_sel=1 -> err pulses about 8 cycles after acceptance; clksel reverts to 0; cur_sel=0; no done.
REQ-035 act matches on exactly cycle ACK_TIMEOUT -> no err; cur_sel updates; done pulses after the dwell.
REQ-036 reset driven low during WAIT_ACK -> clksel=0 and busy=0 without a clock edge; no done/err pulse; normal operation after release.
